// File: rtl/lb_2_cube.sv
// rtl/lb_2_cube.sv - local-buffer tile reader streaming 128-bit words to the cube array
module lb_2_cube #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 6,
    parameter int STRIDE_W = 8,
    parameter int FIFO_D   = 4
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                trans_start,
    output logic                trans_end,
    output logic                busy,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [LEN_W-1:0]    length,
    input  logic [LEN_W-1:0]    height,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                out_last,
    output logic                out_tile_end
);
    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0]   row_base;
    logic [STRIDE_W-1:0] stride_q;
    logic [LEN_W-1:0]    len_q, hgt_q, col, row;
    logic                inflight, inflight_last, inflight_end;
    logic [DATA_W+1:0]   fifo_mem [FIFO_D];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                col_last, row_last, push, pop, start_ok;

    assign start_ok  = (state == IDLE) && trans_start;
    assign col_last  = (col == len_q - LEN_W'(1));
    assign row_last  = (row == hgt_q - LEN_W'(1));
    // Credit counts the read already in flight so the FIFO can never overflow.
    assign rd_en     = (state == RUN) && ((fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_D));
    assign rd_addr   = row_base + ADDR_W'(col);
    assign push      = inflight;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign {out_tile_end, out_last, data_out} = out_valid ? fifo_mem[rd_ptr] : '0;

    always_comb begin
        state_n   = state;
        trans_end = 1'b0;
        busy      = (state != IDLE) || trans_start;
        case (state)
            IDLE:  if (trans_start) state_n = ((length == '0) || (height == '0)) ? DONE : RUN;
            RUN:   if (rd_en && col_last && row_last) state_n = DRAIN;
            // Leave as soon as the final word is being accepted so trans_end follows it directly.
            DRAIN: if (!inflight && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)))
                       state_n = DONE;
            DONE: begin
                trans_end = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            row_base      <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            hgt_q         <= '0;
            col           <= '0;
            row           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_end  <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            state <= state_n;
            if (start_ok) begin
                row_base <= base_addr;
                stride_q <= stride;
                len_q    <= length;
                hgt_q    <= height;
                col      <= '0;
                row      <= '0;
            end else if (rd_en) begin
                if (col_last) begin
                    col      <= '0;
                    row      <= row + LEN_W'(1);
                    row_base <= row_base + ADDR_W'(stride_q);
                end else begin
                    col <= col + LEN_W'(1);
                end
            end
            // Row/tile flags travel alongside the read so they pair with the returning word.
            inflight      <= rd_en;
            inflight_last <= col_last;
            inflight_end  <= col_last && row_last;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {inflight_end, inflight_last, data_in};
    end
endmodule
